// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings,
// FSM state type and the default load-response timeout.
package mem_access_stage_pkg;

    // funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int RSP_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated data,
// plus byte/half extraction and sign/zero extension of load words.
module lsu_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rsp_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = rsp_data[{offset, 3'b000} +: 8];
        ld_half   = rsp_data[{offset[1], 4'b0000} +: 16];
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = rsp_data;

        case (funct3[1:0])
            SZ_B: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                wstrb = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   load_data = {24'd0, ld_byte};
            F3_HU:   load_data = {16'd0, ld_half};
            default: load_data = rsp_data;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: ALU results pass to write-back in one cycle; loads/stores run a
// valid/ready data-memory request while holding upstream via mem_busy.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int RSP_TIMEOUT = RSP_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_alu,
    input  logic        ex_alu_to_reg,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        mem_busy,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic        misaligned,
    output logic        bus_error
);

    state_t      state, state_d;
    logic [31:0] addr_q, sdata_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        store_q;
    logic [7:0]  cnt;

    logic        mem_op, mis_cond;
    logic        do_pass, do_capture, do_mis, do_ld_done, do_timeout;
    logic        cnt_clr, cnt_inc;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_load;

    assign mem_op   = ex_mem_read | ex_mem_write;
    assign mis_cond = ((ex_funct3[1:0] == SZ_H) && ex_alu[0]) ||
                      ((ex_funct3[1:0] == SZ_W) && (ex_alu[1:0] != 2'b00));

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (sdata_q),
        .rsp_data   (dmem_rsp_data),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d        = state;
        mem_busy       = 1'b0;
        dmem_req_valid = 1'b0;
        do_pass        = 1'b0;
        do_capture     = 1'b0;
        do_mis         = 1'b0;
        do_ld_done     = 1'b0;
        do_timeout     = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mem_op) begin
                    do_pass = 1'b1;
                end else if (mis_cond) begin
                    do_mis = 1'b1;
                end else begin
                    mem_busy   = 1'b1;
                    do_capture = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_busy       = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    cnt_clr = 1'b1;
                    state_d = store_q ? ST_DONE : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                mem_busy = 1'b1;
                if (dmem_rsp_valid) begin
                    do_ld_done = 1'b1;
                    state_d    = ST_DONE;
                end else if (cnt == 8'(RSP_TIMEOUT - 1)) begin
                    // cnt counts completed wait cycles, so this is cycle RSP_TIMEOUT
                    do_timeout = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request side is quiet outside REQ so a load never drives enables
    assign dmem_we    = dmem_req_valid & store_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wstrb = dmem_we ? al_wstrb : 4'b0000;
    assign dmem_wdata = dmem_we ? al_wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= 32'd0;
            sdata_q    <= 32'd0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            store_q    <= 1'b0;
            cnt        <= 8'd0;
            wb_data    <= 32'd0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            wb_we      <= 1'b0;
            misaligned <= do_mis;
            bus_error  <= do_timeout;
            if (do_pass) begin
                wb_data <= ex_alu;
                wb_rd   <= ex_rd;
                wb_we   <= ex_alu_to_reg && (ex_rd != 5'd0);
            end
            if (do_capture) begin
                addr_q  <= ex_alu;
                sdata_q <= ex_store_data;
                f3_q    <= ex_funct3;
                rd_q    <= ex_rd;
                store_q <= ex_mem_write & ~ex_mem_read;
            end
            if (do_ld_done) begin
                wb_data <= al_load;
                wb_rd   <= rd_q;
                wb_we   <= (rd_q != 5'd0);
            end
            if (cnt_clr)      cnt <= 8'd0;
            else if (cnt_inc) cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage with a behavioural model
// of lane steering, load extension, alignment and timeout behaviour.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [31:0] ex_alu;
    logic        ex_alu_to_reg;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        mem_busy;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        misaligned;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    mem_access_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ex_alu         (ex_alu),
        .ex_alu_to_reg  (ex_alu_to_reg),
        .ex_rd          (ex_rd),
        .ex_store_data  (ex_store_data),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .mem_busy       (mem_busy),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_data  (dmem_rsp_data),
        .wb_data        (wb_data),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .misaligned     (misaligned),
        .bus_error      (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access of 2**funct3[1:0] bytes at a byte address
    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
        int s;
        s = 1 << f3[1:0];
        return 4'(((1 << s) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint one;
        longint s;
        longint v;
        one = 1;
        s   = one << f3[1:0];
        v   = (longint'(word) >> (8 * (addr % 4))) % (one << (8 * s));
        if (f3[2] == 1'b0 && s < 4 && v >= (one << (8 * s - 1)))
            v = v - (one << (8 * s));
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        ex_alu        = 32'd0;
        ex_alu_to_reg = 1'b0;
        ex_rd         = 5'd0;
        ex_store_data = 32'd0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'd0;
    endtask

    task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic to_reg);
        idle_inputs();
        ex_alu        = val;
        ex_rd         = rd;
        ex_alu_to_reg = to_reg;
        #1;
        chk("alu_busy", 32'(mem_busy), 0);
        @(posedge clk); #1;
        chk("alu_wb_we", 32'(wb_we), 32'(to_reg && rd != 5'd0));
        chk("alu_wb_rd", 32'(wb_rd), 32'(rd));
        chk("alu_wb_data", wb_data, val);
    endtask

    // Runs one memory op from IDLE; returns at IDLE with inputs cleared.
    task automatic mem_op(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int rdy_dly,
                          input int rsp_dly, input logic [31:0] word, input bit no_rsp,
                          output int wait_cycles);
        bit mis;
        int n;
        mis = (addr % (1 << f3[1:0])) != 0;
        wait_cycles = 0;
        ex_mem_read   = is_load;
        ex_mem_write  = !is_load;
        ex_funct3     = f3;
        ex_alu        = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_alu_to_reg = is_load;
        #1;
        chk("idle_busy", 32'(mem_busy), 32'(!mis));
        chk("idle_req", 32'(dmem_req_valid), 0);
        @(posedge clk); #1;
        if (mis) begin
            chk("mis_pulse", 32'(misaligned), 1);
            chk("mis_wb_we", 32'(wb_we), 0);
            chk("mis_req", 32'(dmem_req_valid), 0);
            chk("mis_busy", 32'(mem_busy), 0);
            idle_inputs();
            @(posedge clk); #1;
            chk("mis_pulse_end", 32'(misaligned), 0);
            return;
        end
        chk("no_mis", 32'(misaligned), 0);
        chk("bubble_wb_we", 32'(wb_we), 0);
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", 32'(dmem_req_valid), 1);
            chk("req_busy", 32'(mem_busy), 1);
            chk("req_we", 32'(dmem_we), 32'(!is_load));
            chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("req_wstrb", 32'(dmem_wstrb), is_load ? 0 : 32'(exp_strb(f3, addr)));
            if (!is_load) chk("req_wdata", dmem_wdata, exp_wdata(f3, sdata));
            dmem_req_ready = (i == rdy_dly);
            if (is_load && i == rdy_dly) begin
                dmem_rsp_valid = 1'b1;        // must be ignored in the acceptance cycle
                dmem_rsp_data  = ~word;
            end
            @(posedge clk); #1;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (!is_load) begin
            chk("st_done_busy", 32'(mem_busy), 0);
            chk("st_done_req", 32'(dmem_req_valid), 0);
            chk("st_done_wb_we", 32'(wb_we), 0);
        end else if (no_rsp) begin
            n = 0;
            while (mem_busy === 1'b1 && n < 400) begin
                chk("wait_req_low", 32'(dmem_req_valid), 0);
                n++;
                @(posedge clk); #1;
            end
            wait_cycles = n;
            chk("timeout_cycles", 32'(n), 255);
            chk("timeout_bus_error", 32'(bus_error), 1);
            chk("timeout_wb_we", 32'(wb_we), 0);
        end else begin
            for (int i = 0; i < rsp_dly; i++) begin
                chk("wait_busy", 32'(mem_busy), 1);
                chk("wait_wb_we", 32'(wb_we), 0);
                wait_cycles++;
                @(posedge clk); #1;
            end
            chk("rsp_busy", 32'(mem_busy), 1);
            dmem_rsp_valid = 1'b1;
            dmem_rsp_data  = word;
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
            chk("ld_done_busy", 32'(mem_busy), 0);
            chk("ld_bus_error", 32'(bus_error), 0);
            chk("ld_wb_we", 32'(wb_we), 32'(rd != 5'd0));
            chk("ld_wb_rd", 32'(wb_rd), 32'(rd));
            chk("ld_wb_data", wb_data, exp_load(f3, addr, word));
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("post_wb_we", 32'(wb_we), 0);
        chk("post_bus_error", 32'(bus_error), 0);
        chk("post_busy", 32'(mem_busy), 0);
    endtask

    initial begin
        int wc;
        logic [2:0] ld_f3 [5];
        logic [2:0] f3;
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        idle_inputs();
        reset          = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_req", 32'(dmem_req_valid), 0);
        chk("rst_busy", 32'(mem_busy), 0);
        chk("rst_mis", 32'(misaligned), 0);
        chk("rst_bus_error", 32'(bus_error), 0);
        chk("rst_wstrb", 32'(dmem_wstrb), 0);
        reset = 1'b0;

        // ALU pass-through, including rd=0 suppression
        alu_op(32'h0000_1234, 5'd5, 1'b1);
        alu_op(32'hDEAD_BEEF, 5'd0, 1'b1);
        alu_op(32'h0000_0042, 5'd7, 1'b0);

        // LB at offset 3, response after 3 wait cycles
        mem_op(1'b1, 3'b000, 32'h103, 32'd0, 5'd9, 0, 3, 32'h80FF_FFFF, 1'b0, wc);
        chk("lb_wait_cycles", 32'(wc), 3);

        // SH at offset 2 with ready held low for 2 cycles
        mem_op(1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 5'd3, 2, 0, 32'd0, 1'b0, wc);

        // Misaligned LW
        mem_op(1'b1, 3'b010, 32'h101, 32'd0, 5'd4, 0, 0, 32'd0, 1'b0, wc);

        // LW with no response: timeout
        mem_op(1'b1, 3'b010, 32'h200, 32'd0, 5'd6, 1, 0, 32'd0, 1'b1, wc);

        // Load and store both high behaves as a load
        ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_funct3 = 3'b010;
        ex_alu = 32'h400; ex_rd = 5'd8; #1;
        chk("ldst_busy", 32'(mem_busy), 1);
        @(posedge clk); #1;
        chk("ldst_we", 32'(dmem_we), 0);
        chk("ldst_wstrb", 32'(dmem_wstrb), 0);

        // Reset while waiting for a load response; the late response is dropped
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        chk("rst_mid_busy", 32'(mem_busy), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        ex_alu = 32'h55;
        @(posedge clk); #1;
        reset          = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'hCAFE_F00D;
        chk("rst_mid_req", 32'(dmem_req_valid), 0);
        chk("rst_mid_wb_we", 32'(wb_we), 0);
        chk("rst_mid_wb_data", wb_data, 0);
        chk("rst_mid_busy_after", 32'(mem_busy), 0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        chk("late_rsp_wb_we", 32'(wb_we), 0);
        chk("late_rsp_wb_data", wb_data, 32'h55);
        chk("late_rsp_bus_error", 32'(bus_error), 0);

        // Randomized mix
        for (int t = 0; t < 150; t++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                alu_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                mem_op(1'b1, f3, 32'h2000 + 32'($urandom_range(0, 255)), 32'd0,
                       5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), $urandom, 1'b0, wc);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                mem_op(1'b0, f3, 32'h3000 + 32'($urandom_range(0, 255)), $urandom,
                       5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 0,
                       32'd0, 1'b0, wc);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
